// File: rtl/expression_pipe_eval.sv
// Multi-lane expression evaluator behind a stallable valid/ready register pipeline.
// All lanes share one opcode; each lane's signedness comes from SIGNED_MASK.
module expression_pipe_eval #(
    parameter int unsigned     LANES       = 6,
    parameter int unsigned     W           = 6,
    parameter int unsigned     STAGES      = 2,
    parameter logic [LANES-1:0] SIGNED_MASK = 6'b111000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [LANES*W-1:0]   a,
    input  logic [LANES*W-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   y,
    output logic [15:0]          count
);

    localparam int unsigned DW   = LANES * W;
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] r_valid;
    logic [DW-1:0]     r_data [STAGES];
    logic [15:0]       r_count;

    logic [STAGES-1:0] w_adv;
    logic [DW-1:0]     w_eval;
    logic              w_in_fire;

    // One lane of the shared opcode; result truncated to W bits.
    function automatic logic [W-1:0] lane_eval(input logic [2:0]   f_op,
                                               input logic [W-1:0] f_a,
                                               input logic [W-1:0] f_b,
                                               input logic         f_sgn);
        logic [W-1:0] res;
        logic         lt;
        res = '0;
        lt  = f_sgn ? ($signed(f_a) < $signed(f_b)) : (f_a < f_b);
        case (f_op)
            3'd0: res = f_a + f_b;
            3'd1: res = f_a - f_b;
            3'd2: res = f_a & f_b;
            3'd3: res = f_a ^ ~f_b;
            3'd4: res = f_a << f_b[2:0];
            3'd5: res = f_sgn ? W'($signed(f_a) >>> f_b[2:0]) : (f_a >> f_b[2:0]);
            3'd6: res = {{(W-1){1'b0}}, lt};
            3'd7: res = lt ? f_a : f_b;
        endcase
        return res;
    endfunction

    always_comb begin
        w_eval = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_eval[(int'(LANES)-i)*int'(W)-1 -: W] =
                lane_eval(op,
                          a[(int'(LANES)-i)*int'(W)-1 -: W],
                          b[(int'(LANES)-i)*int'(W)-1 -: W],
                          SIGNED_MASK[i]);
        end
    end

    // A stage advances when out_ready is set or any later stage is empty
    // (the unrolled "successor empty or advancing" chain).
    always_comb begin : p_adv
        logic free;
        w_adv = '0;
        free  = out_ready;
        for (int s = int'(LAST); s >= 0; s--) begin
            w_adv[s] = r_valid[s] && free;
            free     = free || !r_valid[s];
        end
    end

    assign in_ready  = !rst && (!r_valid[0] || w_adv[0]);
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                r_data[s] <= '0;
            end
        end else begin
            if (w_in_fire) begin
                r_data[0] <= w_eval;
            end
            r_valid[0] <= w_in_fire || (r_valid[0] && !w_adv[0]);
            for (int s = 1; s < int'(STAGES); s++) begin
                if (w_adv[s-1]) begin
                    r_data[s] <= r_data[s-1];
                end
                r_valid[s] <= w_adv[s-1] || (r_valid[s] && !w_adv[s]);
            end
            if (r_valid[LAST] && out_ready) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign out_valid = r_valid[LAST];
    assign y         = r_data[LAST];
    assign count     = r_count;

endmodule

// File: tb/tb_expression_pipe_eval.sv
// Directed bench for expression_pipe_eval: opcodes, signedness, stalls and reset.
module tb_expression_pipe_eval;

    localparam int unsigned LANES = 6;
    localparam int unsigned W     = 6;
    localparam int unsigned DW    = LANES * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y;
    logic [15:0]   count;

    int n_checks;
    int n_err;
    int exp_cnt;

    expression_pipe_eval #(
        .LANES      (6),
        .W          (6),
        .STAGES     (2),
        .SIGNED_MASK(6'b111000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] splat(input logic [W-1:0] v);
        return {v, v, v, v, v, v};
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    // One bundle through an idle pipe: accepted at edge k, visible after edge k+1.
    task automatic run_one(input string tag, input logic [2:0] t_op,
                           input logic [DW-1:0] t_a, input logic [DW-1:0] t_b,
                           input logic [DW-1:0] t_y);
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_inrdy"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        check({tag, "_cnt"}, 64'(count), 64'(exp_cnt));
        @(posedge clk); #1;
        check({tag, "_vld"}, 64'(out_valid), 64'd1);
        check({tag, "_y"}, 64'(y), 64'(t_y));
        exp_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int           sent;
        int           recv;
        logic         held;
        logic [DW-1:0] held_y;

        n_checks = 0; n_err = 0; exp_cnt = 0;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        op = 3'd0; a = splat(6'h01); b = splat(6'h01);

        // Reset held for three cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_vld", 64'(out_valid), 64'd0);
            check("rst_y", 64'(y), 64'd0);
            check("rst_cnt", 64'(count), 64'd0);
            check("rst_inrdy", 64'(in_ready), 64'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rel_inrdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        run_one("add_wrap", 3'd0, {6'd63, 6'd0, 6'd0, 6'h1F, 6'd0, 6'd0},
                {6'd1, 6'd0, 6'd0, 6'd1, 6'd0, 6'd0},
                {6'd0, 6'd0, 6'd0, 6'h20, 6'd0, 6'd0});
        run_one("lt", 3'd6, splat(6'h3F), splat(6'h01),
                {6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1});
        run_one("min", 3'd7, splat(6'h3F), splat(6'h01),
                {6'd1, 6'd1, 6'd1, 6'h3F, 6'h3F, 6'h3F});
        run_one("shr", 3'd5, splat(6'h20), splat(6'h02),
                {6'h08, 6'h08, 6'h08, 6'h38, 6'h38, 6'h38});
        run_one("shl", 3'd4, splat(6'h03), splat(6'h03), splat(6'h18));
        run_one("sub", 3'd1, splat(6'h00), splat(6'h01), splat(6'h3F));
        run_one("xnor", 3'd3, splat(6'h0F), splat(6'h33), splat(6'h03));
        run_one("and", 3'd2, splat(6'h2D), splat(6'h1E), splat(6'h0C));

        // Back-pressure: 10 bundles, downstream stalled on cycles 3..8
        do_reset();
        sent = 0; recv = 0; held = 1'b0; held_y = '0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            op        = 3'd0;
            in_valid  = (sent < 10);
            a         = splat(6'(sent));
            b         = splat(6'd1);
            out_ready = !(cyc >= 3 && cyc <= 8);
            #1;
            if (out_valid && out_ready) begin
                check("bp_y", 64'(y), 64'(splat(6'(recv + 1))));
                recv++;
                held = 1'b0;
            end else if (out_valid) begin
                if (held) check("bp_hold", 64'(y), 64'(held_y));
                held_y = y;
                held   = 1'b1;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_recv", 64'(recv), 64'd10);
        check("bp_sent", 64'(sent), 64'd10);
        check("bp_cnt", 64'(count), 64'd10);
        check("bp_empty", 64'(out_valid), 64'd0);

        // Reset with two bundles in flight
        out_ready = 1'b0;
        op = 3'd0; b = splat(6'd0);
        in_valid = 1'b1; a = splat(6'h2A);
        @(posedge clk); #1;
        a = splat(6'h15);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        check("mid_vld", 64'(out_valid), 64'd0);
        check("mid_cnt", 64'(count), 64'd0);
        check("mid_inrdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mid_flush", 64'(out_valid), 64'd0);
        end
        run_one("post_rst", 3'd0, splat(6'h05), splat(6'h01), splat(6'h06));
        @(posedge clk); #1;
        check("post_cnt", 64'(count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
